fibonacci_sequencer: RTL and testbench
======================================

# fibonacci_sequencer

Parametrised Fibonacci/Lucas term generator, successor to `fibonacci_series`, with configurable index and data widths. A start pulse launches a job. The block then streams every term from index 0 to index `number` over a valid/ready interface. It presents the final term on a held result port with a done pulse and a sticky overflow flag. It sits between a control register bank (start/mode/number) and any downstream consumer of the term stream.

## Interface
- `N_W`, 8: width of the requested index `number`.
- `DATA_W`, 20: width of every term; arithmetic is modulo 2^`DATA_W`.
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request; sampled only in IDLE.
- `mode`  in  1  0 = Fibonacci (seeds 0, 1); 1 = Lucas (seeds 2, 1).
- `number`  in  `N_W`  index of the last term; sampled with `start`.
- `busy`  out  1  high in RUN.
- `term_valid`  out  1  stream term present.
- `term_ready`  in  1  consumer accepts term.
- `term_data`  out  `DATA_W`  current term value.
- `term_index`  out  `N_W`  index of the current term.
- `term_last`  out  1  current term is index `number`.
- `fibonacci_number`  out  `DATA_W`  final term of the last completed job, held.
- `done`  out  1  one-cycle completion pulse.
- `overflow`  out  1  last completed job wrapped at or before its final term, held.

## Operation
- Async reset values: state IDLE; `busy`, `term_valid`, `term_last`, `done`, `overflow` = 0; `fibonacci_number`, `term_data`, `term_index` = 0.
- IDLE: when `start`=1, latch `number` -> n_lat and `mode`. Load a = seed0, b = seed1, both wrap bits cleared, idx = 0. Go to RUN.
- RUN: `term_valid`=1, `term_data`=a, `term_index`=idx, `term_last`=(idx==n_lat).
- Handshake: a term transfers when `term_valid && term_ready`. With `term_ready`=0, all stream outputs hold stable; no internal state changes.
- On a transfer with idx != n_lat:
  - a <= b; b <= (a+b) mod 2^`DATA_W`; idx <= idx+1.
  - Wrap tracking: a_wrap <= b_wrap; b_wrap <= carry-out | a_wrap | b_wrap.
- On a transfer with idx == n_lat:
  - `fibonacci_number` <= a; `overflow` <= a_wrap; `done` <= 1 for one cycle.
  - Go to IDLE; `term_valid` drops.
- Overflow reports only terms up to index n. A carry produced while computing the look-ahead term b does not set `overflow` unless that term is later emitted.
- `start` in RUN is ignored. `number`/`mode` changes after launch have no effect on the running job.
- `number`=0: exactly one term (seed0) is emitted with `term_last`=1.
- `reset_n` low mid-job aborts immediately to the reset values; no `done` is produced.

## Timing
- `start` sampled at edge 0; first term valid after edge 0 (cycle 1).
- With `term_ready` tied high: one term per cycle; n+1 terms. The last transfer occurs at edge n+1; `done`/`fibonacci_number`/`overflow` update at edge n+1 (visible in cycle n+2).
- `done` and the IDLE return coincide. A new `start` is accepted in the same cycle `done` is high, so back-to-back jobs have no idle bubble beyond that cycle.
- Each stall cycle on `term_ready` adds exactly one cycle of latency.
- All outputs are registered; no combinational path from `term_ready` to `term_valid`.

## Test plan
- Fibonacci, defaults, `number`=10, ready high -> stream 0,1,1,2,3,5,8,13,21,34,55. `term_last` is asserted on index 10 only. `fibonacci_number`=55, `overflow`=0, `done` in cycle 12.
- Fibonacci `number`=30 -> `fibonacci_number`=832040, `overflow`=0. This holds even though the look-ahead F(31) wraps.
- Fibonacci `number`=31 -> `fibonacci_number`=297693 (1346269 mod 2^20), `overflow`=1. A following job with `number`=5 gives 5 and clears `overflow`.
- Lucas `number`=10 -> stream 2,1,3,4,7,11,18,29,47,76,123; `fibonacci_number`=123. Lucas `number`=0 -> single term 2.
- Backpressure: `number`=6 with `term_ready` toggled pseudo-randomly. Outputs stay stable while stalled, every index 0..6 is delivered exactly once, and `done` follows the last transfer by one edge. A `start` pulsed mid-run is ignored.
- Reset: assert `reset_n`=0 at term 4 of a `number`=10 job. All outputs are 0 at once, there is no `done`, and a fresh job afterwards returns 55.

Source files
------------

// File: rtl/fibonacci_sequencer.sv
// Fibonacci/Lucas term streamer: emits terms 0..number over valid/ready,
// then holds the final term with a done pulse and a sticky wrap flag.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for start; result/overflow held from last job
// ST_RUN  | streaming term idx_q; advances only on a valid&ready transfer
module fibonacci_sequencer #(
  parameter int N_W    = 8,
  parameter int DATA_W = 20
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [N_W-1:0]    number,
  output logic              busy,
  output logic              term_valid,
  input  logic              term_ready,
  output logic [DATA_W-1:0] term_data,
  output logic [N_W-1:0]    term_index,
  output logic              term_last,
  output logic [DATA_W-1:0] fibonacci_number,
  output logic              done,
  output logic              overflow
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [N_W-1:0]    n_lat_q, n_lat_d;
  logic [N_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              a_wrap_q, a_wrap_d;
  logic              b_wrap_q, b_wrap_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] fib_q, fib_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic [DATA_W:0]   sum;
  logic [N_W-1:0]    idx_inc;

  assign sum     = {1'b0, a_q} + {1'b0, b_q};
  assign idx_inc = idx_q + N_W'(1);

  always_comb begin
    state_d  = state_q;
    n_lat_d  = n_lat_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    a_wrap_d = a_wrap_q;
    b_wrap_d = b_wrap_q;
    last_d   = last_q;
    fib_d    = fib_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start) begin
        state_d  = ST_RUN;
        n_lat_d  = number;
        a_d      = mode ? DATA_W'(2) : '0;
        b_d      = DATA_W'(1);
        a_wrap_d = 1'b0;
        b_wrap_d = 1'b0;
        idx_d    = '0;
        last_d   = (number == '0);
      end
    end else if (term_ready) begin
      if (last_q) begin
        fib_d   = a_q;
        ovf_d   = a_wrap_q;
        done_d  = 1'b1;
        last_d  = 1'b0;
        state_d = ST_IDLE;
      end else begin
        // b carries the look-ahead term; its wrap only matters once it reaches a
        a_d      = b_q;
        b_d      = sum[DATA_W-1:0];
        a_wrap_d = b_wrap_q;
        b_wrap_d = sum[DATA_W] | a_wrap_q | b_wrap_q;
        idx_d    = idx_inc;
        last_d   = (idx_inc == n_lat_q);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      n_lat_q  <= '0;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      a_wrap_q <= 1'b0;
      b_wrap_q <= 1'b0;
      last_q   <= 1'b0;
      fib_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_lat_q  <= n_lat_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_wrap_q <= a_wrap_d;
      b_wrap_q <= b_wrap_d;
      last_q   <= last_d;
      fib_q    <= fib_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy             = (state_q == ST_RUN);
  assign term_valid       = (state_q == ST_RUN);
  assign term_data        = a_q;
  assign term_index       = idx_q;
  assign term_last        = last_q;
  assign fibonacci_number = fib_q;
  assign done             = done_q;
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_fibonacci_sequencer.sv
// Randomized bench for fibonacci_sequencer against an exact-value sequence model.
module tb_fibonacci_sequencer;

  localparam int N_W    = 8;
  localparam int DATA_W = 20;

  logic              clock;
  logic              reset_n;
  logic              start;
  logic              mode;
  logic [N_W-1:0]    number;
  logic              busy;
  logic              term_valid;
  logic              term_ready;
  logic [DATA_W-1:0] term_data;
  logic [N_W-1:0]    term_index;
  logic              term_last;
  logic [DATA_W-1:0] fibonacci_number;
  logic              done;
  logic              overflow;

  int n_cmp = 0;
  int n_mis = 0;

  // model: modular term values plus saturated true values for overflow
  logic [DATA_W-1:0] exp_term [0:256];
  longint            exact    [0:256];
  longint            modv     [0:256];
  logic              exp_ovf;

  fibonacci_sequencer #(.N_W(N_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mode(mode), .number(number),
    .busy(busy), .term_valid(term_valid), .term_ready(term_ready),
    .term_data(term_data), .term_index(term_index), .term_last(term_last),
    .fibonacci_number(fibonacci_number), .done(done), .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic build_model(input logic m, input int n);
    longint lim;
    longint cap;
    lim = longint'(1) << DATA_W;
    cap = longint'(1) << 40;
    exact[0] = m ? 2 : 0;
    exact[1] = 1;
    for (int k = 2; k <= 256; k++) begin
      exact[k] = exact[k-1] + exact[k-2];
      if (exact[k] > cap) exact[k] = cap;
    end
    modv[0] = exact[0];
    modv[1] = 1;
    for (int k = 2; k <= 256; k++) modv[k] = (modv[k-1] + modv[k-2]) % lim;
    for (int k = 0; k <= 256; k++) exp_term[k] = modv[k][DATA_W-1:0];
    exp_ovf = (exact[n] >= lim);
  endtask

  // entered and left at #1 after a rising edge
  task automatic run_job(input logic m, input int n, input int rdy_pct, input bit poke);
    int k;
    int edges;
    int budget;
    logic rdy;
    build_model(m, n);
    budget = (n + 1) * 40 + 20;
    chk("launch_busy", busy, 0);
    mode   = m;
    number = n[N_W-1:0];
    start  = 1'b1;
    @(posedge clock); #1;
    start  = 1'b0;
    number = N_W'($urandom);
    mode   = 1'($urandom);
    k = 0;
    edges = 1;
    while (k <= n && edges < budget) begin
      chk("valid", term_valid, 1);
      chk("busy", busy, 1);
      chk("index", term_index, k);
      chk("data", term_data, exp_term[k]);
      chk("last", term_last, (k == n));
      chk("done_early", done, 0);
      rdy = ($urandom_range(0, 99) < rdy_pct);
      term_ready = rdy;
      start = poke && ($urandom_range(0, 3) == 0);
      @(posedge clock); #1;
      edges++;
      if (rdy) k++;
    end
    start = 1'b0;
    term_ready = 1'($urandom);
    chk("job_complete", k, n + 1);
    chk("done", done, 1);
    chk("result", fibonacci_number, exp_term[n]);
    chk("overflow", overflow, exp_ovf);
    chk("valid_drop", term_valid, 0);
    chk("last_drop", term_last, 0);
  endtask

  task automatic idle_cycles(input int cnt);
    logic [DATA_W-1:0] held;
    held = fibonacci_number;
    for (int i = 0; i < cnt; i++) begin
      @(posedge clock); #1;
      chk("idle_valid", term_valid, 0);
      chk("idle_done", done, 0);
      chk("idle_result_held", fibonacci_number, held);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_busy", busy, 0);
    chk("rst_valid", term_valid, 0);
    chk("rst_last", term_last, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_result", fibonacci_number, 0);
    chk("rst_data", term_data, 0);
    chk("rst_index", term_index, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    mode       = 1'b0;
    number     = '0;
    term_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_values();
    reset_n = 1'b1;
    idle_cycles(2);

    run_job(1'b0, 10, 100, 1'b0);
    idle_cycles(2);
    run_job(1'b0, 30, 100, 1'b0);
    run_job(1'b0, 31, 100, 1'b0);
    run_job(1'b0, 5, 100, 1'b0);
    run_job(1'b1, 10, 100, 1'b0);
    run_job(1'b1, 0, 100, 1'b0);
    run_job(1'b0, 0, 70, 1'b0);
    idle_cycles(1);
    run_job(1'b0, 6, 50, 1'b1);
    idle_cycles(1);

    for (int j = 0; j < 20; j++) begin
      run_job(1'($urandom_range(0, 1)), $urandom_range(0, 50), $urandom_range(30, 100), 1'b1);
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
    end
    run_job(1'b1, 255, 90, 1'b1);
    idle_cycles(1);

    // abort a number=10 job while term 4 is on the stream
    term_ready = 1'b1;
    mode   = 1'b0;
    number = N_W'(10);
    start  = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clock); #1;
    end
    chk("pre_reset_index", term_index, 4);
    reset_n = 1'b0;
    #1;
    check_reset_values();
    @(posedge clock); #1;
    chk("reset_no_done", done, 0);
    reset_n = 1'b1;
    idle_cycles(1);
    run_job(1'b0, 10, 100, 1'b0);
    idle_cycles(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
